// File: rtl/jesd_bringup_sequencer.sv
// jesd_bringup_sequencer: CPU-less AXI-Lite master that brings up the JESD204
// TX, RX and PHY cores. It pulses the TX/RX core resets, reads the three version
// registers, then polls TX/RX reset-done, RX SYNC and RX data-started.
// Ports:
//   SAXI_aclk, reset     clock and async active-high reset
//   start                1-cycle pulse, honoured only in IDLE/DONE/ERROR
//   busy, done, error    sequence status levels; err_code gives the failure cause
//   tx/rx/phy_version    captured version words; rx_status = last RX 0x060 read
//   m_aw*/m_w*/m_b*      AXI-Lite write channel (master side)
//   m_ar*/m_r*           AXI-Lite read channel (master side)
module jesd_bringup_sequencer #(
  parameter logic [31:0] TX_ADDR    = 32'h44A4_0000,
  parameter logic [31:0] RX_ADDR    = 32'h44A3_0000,
  parameter logic [31:0] PHY_ADDR   = 32'h44A0_0000,
  parameter int unsigned POLL_GAP   = 16,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic        SAXI_aclk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code,
  output logic [31:0] tx_version,
  output logic [31:0] rx_version,
  output logic [31:0] phy_version,
  output logic [31:0] rx_status,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready
);

  localparam int unsigned CNT_W   = 11;
  localparam int unsigned GAP_W   = $clog2(POLL_GAP + 1);
  localparam logic [31:0] REG_RST = 32'h0000_0020;
  localparam logic [31:0] RX_STAT = RX_ADDR + 32'h0000_0060;

  typedef enum logic [3:0] {
    IDLE, WR_TXRST, WR_RXRST, RD_TXVER, RD_RXVER, RD_PHYVER,
    POLL_TXRST, POLL_RXRST, POLL_SYNC, POLL_START, DONE, ERROR
  } state_t;

  state_t             state;
  logic               active;     // a transaction is outstanding on the bus
  logic               aw_ok;
  logic               w_ok;
  logic [GAP_W-1:0]   gap_cnt;
  logic [CNT_W-1:0]   poll_cnt;

  logic [31:0]        addr_c;
  logic               wr_c;
  logic               pass_c;
  logic [2:0]         tmo_c;
  state_t             next_c;
  logic [CNT_W:0]     poll_nxt_c;

  // Per-state access decode: address, direction, successor and poll condition.
  // Non-poll reads always pass so that all reads share one completion path.
  always_comb begin
    addr_c     = TX_ADDR + REG_RST;
    wr_c       = 1'b0;
    pass_c     = 1'b1;
    tmo_c      = 3'd0;
    next_c     = IDLE;
    poll_nxt_c = {1'b0, poll_cnt} + (CNT_W+1)'(1);
    case (state)
      WR_TXRST:   begin addr_c = TX_ADDR + REG_RST; wr_c = 1'b1; next_c = WR_RXRST; end
      WR_RXRST:   begin addr_c = RX_ADDR + REG_RST; wr_c = 1'b1; next_c = RD_TXVER; end
      RD_TXVER:   begin addr_c = TX_ADDR;  next_c = RD_RXVER;   end
      RD_RXVER:   begin addr_c = RX_ADDR;  next_c = RD_PHYVER;  end
      RD_PHYVER:  begin addr_c = PHY_ADDR; next_c = POLL_TXRST; end
      POLL_TXRST: begin addr_c = TX_ADDR + REG_RST; next_c = POLL_RXRST; pass_c = ~m_rdata[0];  tmo_c = 3'd3; end
      POLL_RXRST: begin addr_c = RX_ADDR + REG_RST; next_c = POLL_SYNC;  pass_c = ~m_rdata[0];  tmo_c = 3'd4; end
      POLL_SYNC:  begin addr_c = RX_STAT; next_c = POLL_START; pass_c = m_rdata[12]; tmo_c = 3'd5; end
      POLL_START: begin addr_c = RX_STAT; next_c = DONE;       pass_c = m_rdata[14]; tmo_c = 3'd6; end
      default:    ;
    endcase
  end

  // Sequencer FSM with bus handshakes; all outputs registered.
  always_ff @(posedge SAXI_aclk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      active      <= 1'b0;
      aw_ok       <= 1'b0;
      w_ok        <= 1'b0;
      gap_cnt     <= '0;
      poll_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= 3'd0;
      tx_version  <= '0;
      rx_version  <= '0;
      phy_version <= '0;
      rx_status   <= '0;
      m_awaddr    <= '0;
      m_awvalid   <= 1'b0;
      m_wdata     <= '0;
      m_wvalid    <= 1'b0;
      m_bready    <= 1'b0;
      m_araddr    <= '0;
      m_arvalid   <= 1'b0;
      m_rready    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state    <= WR_TXRST;
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= 3'd0;
            poll_cnt <= '0;
            gap_cnt  <= '0;
          end
        end
        default: begin
          if (!active) begin
            // Issue the next access once the poll gap has elapsed.
            if (gap_cnt != '0) begin
              gap_cnt <= gap_cnt - GAP_W'(1);
            end else begin
              active <= 1'b1;
              if (wr_c) begin
                m_awaddr  <= addr_c;
                m_wdata   <= 32'h0000_0001;
                m_awvalid <= 1'b1;
                m_wvalid  <= 1'b1;
                aw_ok     <= 1'b0;
                w_ok      <= 1'b0;
              end else begin
                m_araddr  <= addr_c;
                m_arvalid <= 1'b1;
              end
            end
          end else if (wr_c) begin
            if (m_awvalid && m_awready) begin
              m_awvalid <= 1'b0;
              aw_ok     <= 1'b1;
            end
            if (m_wvalid && m_wready) begin
              m_wvalid <= 1'b0;
              w_ok     <= 1'b1;
            end
            // B is accepted only after both address and data are taken.
            if (!m_bready && (aw_ok || (m_awvalid && m_awready)) &&
                (w_ok || (m_wvalid && m_wready))) begin
              m_bready <= 1'b1;
            end
            if (m_bready && m_bvalid) begin
              m_bready <= 1'b0;
              active   <= 1'b0;
              if (m_bresp != 2'b00) begin
                state    <= ERROR;
                error    <= 1'b1;
                busy     <= 1'b0;
                err_code <= 3'd1;
              end else begin
                state    <= next_c;
                poll_cnt <= '0;
              end
            end
          end else begin
            if (m_arvalid && m_arready) begin
              m_arvalid <= 1'b0;
              m_rready  <= 1'b1;
            end
            if (m_rready && m_rvalid) begin
              m_rready <= 1'b0;
              active   <= 1'b0;
              if (m_araddr == RX_STAT) rx_status <= m_rdata;
              if (m_rresp != 2'b00) begin
                state    <= ERROR;
                error    <= 1'b1;
                busy     <= 1'b0;
                err_code <= 3'd2;
              end else if (pass_c) begin
                if (state == RD_TXVER)  tx_version  <= m_rdata;
                if (state == RD_RXVER)  rx_version  <= m_rdata;
                if (state == RD_PHYVER) phy_version <= m_rdata;
                state    <= next_c;
                poll_cnt <= '0;
                if (next_c == DONE) begin
                  done <= 1'b1;
                  busy <= 1'b0;
                end
              end else if (poll_nxt_c >= (CNT_W+1)'(POLL_LIMIT)) begin
                state    <= ERROR;
                error    <= 1'b1;
                busy     <= 1'b0;
                err_code <= tmo_c;
              end else begin
                if (poll_cnt != '1) poll_cnt <= poll_cnt + CNT_W'(1);
                gap_cnt <= GAP_W'(POLL_GAP);
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jesd_bringup_sequencer.sv
// tb_jesd_bringup_sequencer: directed bench for the JESD bring-up sequencer with a
// behavioural AXI-Lite slave (configurable AW/W ready delays, error injection).
module tb_jesd_bringup_sequencer;

  localparam logic [31:0] TXA  = 32'h44A4_0000;
  localparam logic [31:0] RXA  = 32'h44A3_0000;
  localparam logic [31:0] PHYA = 32'h44A0_0000;
  localparam logic [31:0] TXV  = 32'h0107_0A61;
  localparam logic [31:0] RXV  = 32'h0107_0A62;
  localparam logic [31:0] PHYV = 32'h0100_0161;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [2:0]  err_code;
  logic [31:0] tx_version, rx_version, phy_version, rx_status;
  logic [31:0] awaddr, wdata, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp = 2'b00;
  logic [1:0]  rresp = 2'b00;
  logic [31:0] rdata = '0;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  jesd_bringup_sequencer #(
    .TX_ADDR(TXA), .RX_ADDR(RXA), .PHY_ADDR(PHYA), .POLL_GAP(2), .POLL_LIMIT(4)
  ) dut (
    .SAXI_aclk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .tx_version(tx_version), .rx_version(rx_version), .phy_version(phy_version),
    .rx_status(rx_status),
    .m_awaddr(awaddr), .m_awvalid(awvalid), .m_awready(awready),
    .m_wdata(wdata), .m_wvalid(wvalid), .m_wready(wready),
    .m_bresp(bresp), .m_bvalid(bvalid), .m_bready(bready),
    .m_araddr(araddr), .m_arvalid(arvalid), .m_arready(arready),
    .m_rdata(rdata), .m_rresp(rresp), .m_rvalid(rvalid), .m_rready(rready)
  );

  // ---------------- slave model ----------------
  int          aw_dly = 0, w_dly = 0, aw_cnt = 0, w_cnt = 0;
  bit          aw_got = 0, w_got = 0, b_early = 0, sync_en = 1;
  int          b_cnt = 0, tx_rst_rd = 0, rx_rst_rd = 0, stat_rd = 0;
  logic [31:0] bad_addr = 32'hFFFF_FFFF;
  logic [32:0] acc_q[$];
  logic        bv = 1'b0;
  logic        rv = 1'b0;

  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid && (w_cnt >= w_dly);
  assign arready = arvalid;
  assign bvalid  = bv;
  assign rvalid  = rv;

  // Reset registers read 1 on the first two polls after a reset write, then 0.
  function automatic logic [31:0] rd_val(input logic [31:0] a);
    logic [31:0] v;
    v = 32'hDEAD_BEEF;
    if (a == TXA) v = TXV;
    else if (a == RXA) v = RXV;
    else if (a == PHYA) v = PHYV;
    else if (a == TXA + 32'h20) v = (tx_rst_rd < 2) ? 32'h1 : 32'h0;
    else if (a == RXA + 32'h20) v = (rx_rst_rd < 2) ? 32'h1 : 32'h0;
    else if (a == RXA + 32'h60) begin
      v = 32'h0;
      if (sync_en && stat_rd >= 2) v[12] = 1'b1;
      if (stat_rd >= 5) v[14] = 1'b1;
    end
    return v;
  endfunction

  always @(posedge clk) begin
    aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
    w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
    if (bready && !bv && !(aw_got && w_got)) b_early <= 1'b1;
    if (awvalid && awready) begin
      aw_got <= 1'b1;
      acc_q.push_back({1'b1, awaddr});
      if (awaddr == TXA + 32'h20) tx_rst_rd <= 0;
      if (awaddr == RXA + 32'h20) begin rx_rst_rd <= 0; stat_rd <= 0; end
    end
    if (wvalid && wready) w_got <= 1'b1;
    if (aw_got && w_got && !bv) begin
      bv <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
    end
    if (bv && bready) begin bv <= 1'b0; b_cnt <= b_cnt + 1; end
    if (arvalid && arready) begin
      acc_q.push_back({1'b0, araddr});
      rv    <= 1'b1;
      rdata <= rd_val(araddr);
      rresp <= (araddr == bad_addr) ? 2'b10 : 2'b00;
      if (araddr == TXA + 32'h20) tx_rst_rd <= tx_rst_rd + 1;
      if (araddr == RXA + 32'h20) rx_rst_rd <= rx_rst_rd + 1;
      if (araddr == RXA + 32'h60) stat_rd <= stat_rd + 1;
    end
    if (rv && rready) rv <= 1'b0;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    check_eq(tag, 64'(busy), 64'd0);
  endtask

  function automatic logic [32:0] acc_at(input int idx);
    logic [32:0] v;
    v = 33'h0;
    if (idx < acc_q.size()) v = acc_q[idx];
    return v;
  endfunction

  logic [32:0] exp_seq[17];
  int base, bbase, n, hits;

  initial begin
    exp_seq[0] = {1'b1, TXA + 32'h20};
    exp_seq[1] = {1'b1, RXA + 32'h20};
    exp_seq[2] = {1'b0, TXA};
    exp_seq[3] = {1'b0, RXA};
    exp_seq[4] = {1'b0, PHYA};
    for (int i = 5; i < 8; i++)   exp_seq[i] = {1'b0, TXA + 32'h20};
    for (int i = 8; i < 11; i++)  exp_seq[i] = {1'b0, RXA + 32'h20};
    for (int i = 11; i < 17; i++) exp_seq[i] = {1'b0, RXA + 32'h60};

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 0);
    check_eq("rst_flags", {61'd0, done, error, awvalid}, 0);
    check_eq("rst_valids", {60'd0, wvalid, bready, arvalid, rready}, 0);
    check_eq("rst_errcode", 64'(err_code), 0);
    check_eq("rst_awaddr", 64'(awaddr), 0);
    check_eq("rst_txver", 64'(tx_version), 0);
    reset = 1'b0;

    // 1: nominal sequence, exact access order
    base = acc_q.size();
    pulse_start();
    check_eq("t1_busy", 64'(busy), 1);
    wait_idle("t1_timeout");
    check_eq("t1_count", 64'(acc_q.size() - base), 17);
    for (int i = 0; i < 17; i++) check_eq($sformatf("t1_acc%0d", i), 64'(acc_at(base + i)), 64'(exp_seq[i]));
    check_eq("t1_done", 64'(done), 1);
    check_eq("t1_error", 64'(error), 0);
    check_eq("t1_errcode", 64'(err_code), 0);
    check_eq("t1_txver", 64'(tx_version), 64'(TXV));
    check_eq("t1_rxver", 64'(rx_version), 64'(RXV));
    check_eq("t1_phyver", 64'(phy_version), 64'(PHYV));
    check_eq("t1_rxstat", 64'(rx_status), 64'h5000);

    // 6: start while busy ignored, start in DONE repeats
    base = acc_q.size();
    pulse_start();
    check_eq("t6_done_low", 64'(done), 0);
    repeat (10) @(negedge clk);
    pulse_start();
    check_eq("t6_busy", 64'(busy), 1);
    wait_idle("t6_timeout");
    check_eq("t6_count", 64'(acc_q.size() - base), 17);
    check_eq("t6_done", 64'(done), 1);

    // 2: awready late, then wready late
    for (int k = 0; k < 2; k++) begin
      aw_dly = (k == 0) ? 2 : 0;
      w_dly  = (k == 0) ? 0 : 2;
      bbase  = b_cnt;
      pulse_start();
      wait_idle("t2_timeout");
      check_eq($sformatf("t2_bcnt%0d", k), 64'(b_cnt - bbase), 2);
      check_eq($sformatf("t2_early%0d", k), 64'(b_early), 0);
      check_eq($sformatf("t2_done%0d", k), 64'(done), 1);
    end
    aw_dly = 0; w_dly = 0;

    // 4: RRESP error on RX version read
    bad_addr = RXA;
    base = acc_q.size();
    pulse_start();
    wait_idle("t4_timeout");
    check_eq("t4_error", 64'(error), 1);
    check_eq("t4_errcode", 64'(err_code), 2);
    check_eq("t4_done", 64'(done), 0);
    repeat (20) @(negedge clk);
    check_eq("t4_count", 64'(acc_q.size() - base), 4);
    check_eq("t4_last", 64'(acc_at(base + 3)), 64'({1'b0, RXA}));
    bad_addr = 32'hFFFF_FFFF;

    // 3: SYNC never asserted -> timeout after exactly 4 reads
    sync_en = 1'b0;
    base = acc_q.size();
    pulse_start();
    check_eq("t3_err_cleared", {61'd0, error, err_code}, 0);
    wait_idle("t3_timeout");
    check_eq("t3_error", 64'(error), 1);
    check_eq("t3_errcode", 64'(err_code), 5);
    hits = 0;
    for (int i = base; i < acc_q.size(); i++) if (acc_q[i] == {1'b0, RXA + 32'h60}) hits++;
    check_eq("t3_syncreads", 64'(hits), 4);
    check_eq("t3_rxstat", 64'(rx_status), 0);
    sync_en = 1'b1;

    // 5: async reset while arvalid is high
    pulse_start();
    n = 0;
    while (!arvalid && n < 100) begin @(negedge clk); n++; end
    check_eq("t5_arvalid_seen", 64'(arvalid), 1);
    reset = 1'b1;
    #1;
    check_eq("t5_arvalid", 64'(arvalid), 0);
    check_eq("t5_busy", 64'(busy), 0);
    check_eq("t5_araddr", 64'(araddr), 0);
    check_eq("t5_flags", {60'd0, error, err_code}, 0);
    check_eq("t5_txver", 64'(tx_version), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t5_idle", {61'd0, busy, done, rready}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
